toggle_check_bank: RTL
======================

# toggle_check_bank

Synthesizable, parametrised follow/complement checker for a bank of enable-gated toggle or delay elements. It is the runtime successor to the single-channel SVA toggle assertions. Each channel watches `en`, `q` and `z` and flags a violation when `z` fails to equal `q` from `LATENCY` cycles earlier, optionally inverted, while `en` is held. Violations are reported as per-channel pulses, sticky flags and saturating counters, plus a first-failure capture, so the block can sit in silicon or FPGA builds next to the circuit under check.

## Interface
- `CHANNELS`, default 4: number of independent channels, range 1..32.
- `LATENCY`, default 1: cycles between the `q` sample and the `z` check, range 1..8.
- `COUNT_W`, default 8: width of each per-channel error counter, at least 1.
- `INVERT_MASK`, default 0: `CHANNELS` bits. Bit i = 1 means channel i expects `z` = ~`q`; bit i = 0 means it expects `z` = `q`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  `CHANNELS`  per-channel enable.
- `q`  in  `CHANNELS`  per-channel reference value.
- `z`  in  `CHANNELS`  per-channel observed output.
- `clear`  in  1  synchronous clear of sticky flags, counters and first-fail capture.
- `fail`  out  `CHANNELS`  one-cycle violation pulse per channel.
- `err_sticky`  out  `CHANNELS`  latched violation flag per channel.
- `err_count`  out  `CHANNELS*COUNT_W`  saturating counters; channel i occupies bits [i*COUNT_W +: COUNT_W].
- `any_err`  out  1  OR-reduction of `err_sticky`.
- `first_valid`  out  1  set when `first_chan` holds a capture.
- `first_chan`  out  max(1,$clog2(`CHANNELS`))  index of the first failing channel.

## Operation
- Per channel i, keep a `LATENCY`-deep history of `q[i]` and an enable-run counter `run[i]`.
  - `run[i]` increments while `en[i]` = 1 and saturates at `LATENCY`.
  - `run[i]` goes to 0 in any cycle where `en[i]` = 0.
- A check is armed on channel i in cycle t when `en[i]` = 1 in cycle t and `run[i]` = `LATENCY`. This means `en` was high on every cycle from t−`LATENCY` to t.
- Expected value: `qhist[i]`(t−`LATENCY`) XOR `INVERT_MASK[i]`.
- Violation: the check is armed and `z[i]` ≠ the expected value.
- When `en[i]` is low, the check is disabled, matching the `!en ||` form of the original properties.
- On each violation on channel i:
  - `fail[i]` pulses.
  - `err_sticky[i]` sets.
  - `err_count[i]` increments, saturating at 2^`COUNT_W`−1 with no wrap.
- First-fail capture:
  - In the first cycle with any violation while `first_valid` = 0, `first_chan` takes the lowest failing index and `first_valid` is set.
  - Later violations do not change the capture until `clear`.
- `clear`:
  - Zeroes `err_sticky`, `err_count`, `first_valid` and `first_chan`.
  - Does not touch the history or `run`, so checking continues.
  - A violation in the same cycle as `clear` wins over the clear: sticky = 1, count = 1, and the capture is taken.
- `reset`:
  - Zeroes every register, including history and `run`. This acts as a disable: no check can fire until `LATENCY` cycles of held `en` have passed after reset deasserts.
  - Reset asserted mid-run aborts any pending checks; no `fail` is produced for the window that was cut off.

## Timing
- All outputs are registered. A violation sampled at edge t appears on `fail`, `err_sticky`, `err_count`, `any_err` and `first_*` after edge t+1.
  - Latency from the `q` sample to `fail` visibility is `LATENCY`+1 cycles.
- Reset value of every output is 0.
- Earliest possible `fail` after reset deasserts: `LATENCY`+1 cycles, with `en` held high from the first cycle out of reset.
- Any `en` drop restarts the warm-up for that channel only. Channels are fully independent.
- Multiple channels can fail in the same cycle: each counter updates independently, and `first_chan` takes the lowest index.

## Test plan
- Follow mode, `LATENCY`=1, channel 0: hold `en`=1, `z` = `q` delayed by 1, toggle `q` for 20 cycles. Required: `fail`=0, `err_count`=0, `any_err`=0 throughout.
- Channel 2 with `INVERT_MASK` bit 2 = 1: drive `q`=1 at t and `z`=1 at t+1. Required: `fail[2]`=1 at t+2 only, `err_count[2]`=1, `first_chan`=2, `first_valid`=1.
- `LATENCY`=3: drop `en` for one cycle inside the window and drive a wrong `z`. Required: no `fail` until 3 further held cycles have passed; the next mismatch then fails.
- `COUNT_W`=2: force a mismatch every cycle for 6 cycles. Required: `err_count` goes 1, 2, 3, then holds at 3; `fail` is high for all 6 cycles.
- Channels 1 and 3 fail in the same cycle. Required: `first_chan`=1. Then assert `clear` in the same cycle as a new channel-3 failure. Required: `err_count[1]`=0, `err_count[3]`=1, `first_chan`=3.
- Assert `reset` mid-window with a mismatch pending, then deassert. Required: all outputs 0, no `fail` for the aborted window, and the first check fires only after `LATENCY` held cycles.

Source files
------------

// File: rtl/toggle_check_bank_if.sv
// toggle_check_bank_if: observation inputs and violation reporting outputs of the checker bank
interface toggle_check_bank_if #(
    parameter int CHANNELS = 4,
    parameter int COUNT_W  = 8
);
    localparam int FC_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]         en;
    logic [CHANNELS-1:0]         q;
    logic [CHANNELS-1:0]         z;
    logic                        clear;
    logic [CHANNELS-1:0]         fail;
    logic [CHANNELS-1:0]         err_sticky;
    logic [CHANNELS*COUNT_W-1:0] err_count;
    logic                        any_err;
    logic                        first_valid;
    logic [FC_W-1:0]             first_chan;

    modport master (
        output en, q, z, clear,
        input  fail, err_sticky, err_count, any_err, first_valid, first_chan
    );

    modport slave (
        input  en, q, z, clear,
        output fail, err_sticky, err_count, any_err, first_valid, first_chan
    );
endinterface

// File: rtl/toggle_check_bank.sv
// toggle_check_bank: per-channel follow/complement checker with pulses, sticky flags, counters and first-fail capture
module toggle_check_bank #(
    parameter int                  CHANNELS    = 4,
    parameter int                  LATENCY     = 1,
    parameter int                  COUNT_W     = 8,
    parameter logic [CHANNELS-1:0] INVERT_MASK = '0
) (
    input logic                clk,
    input logic                reset,
    toggle_check_bank_if.slave bus
);
    localparam int FC_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int RUN_W = $clog2(LATENCY + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LATENCY);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [CHANNELS-1:0] hist [LATENCY];
    logic [RUN_W-1:0]    run  [CHANNELS];
    logic [COUNT_W-1:0]  cnt  [CHANNELS];
    logic [CHANNELS-1:0] armed;
    logic [CHANNELS-1:0] viol;
    logic [CHANNELS-1:0] fail;
    logic [CHANNELS-1:0] sticky;
    logic                first_valid;
    logic [FC_W-1:0]     first_chan;
    logic [FC_W-1:0]     low_idx;

    // a check fires only after LATENCY+1 consecutive enabled cycles; expected value is the oldest history tap
    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            armed[i] = bus.en[i] && (run[i] == RUN_MAX);
        viol = armed & (bus.z ^ hist[LATENCY-1] ^ INVERT_MASK);
    end

    // lowest violating channel index, scanned from the top so the lowest wins
    always_comb begin
        low_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (viol[i]) low_idx = FC_W'(i);
    end

    // q history shift and per-channel enable-run counters; only reset touches these
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) hist[k] <= '0;
            for (int i = 0; i < CHANNELS; i++) run[i] <= '0;
        end else begin
            hist[0] <= bus.q;
            for (int k = 1; k < LATENCY; k++) hist[k] <= hist[k-1];
            for (int i = 0; i < CHANNELS; i++)
                run[i] <= !bus.en[i] ? '0 : (run[i] == RUN_MAX ? RUN_MAX : run[i] + 1'b1);
        end
    end

    // violation reporting; a same-cycle violation overrides clear
    always_ff @(posedge clk) begin
        if (reset) begin
            fail        <= '0;
            sticky      <= '0;
            first_valid <= 1'b0;
            first_chan  <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else begin
            fail   <= viol;
            sticky <= (bus.clear ? '0 : sticky) | viol;
            for (int i = 0; i < CHANNELS; i++)
                cnt[i] <= viol[i] ? (bus.clear ? COUNT_W'(1) : (cnt[i] == CNT_MAX ? CNT_MAX : cnt[i] + 1'b1))
                                  : (bus.clear ? '0 : cnt[i]);
            if ((bus.clear || !first_valid) && |viol) begin
                first_valid <= 1'b1;
                first_chan  <= low_idx;
            end else if (bus.clear) begin
                first_valid <= 1'b0;
                first_chan  <= '0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_cnt
            assign bus.err_count[g*COUNT_W +: COUNT_W] = cnt[g];
        end
    endgenerate

    assign bus.fail        = fail;
    assign bus.err_sticky  = sticky;
    assign bus.any_err     = |sticky;
    assign bus.first_valid = first_valid;
    assign bus.first_chan  = first_chan;
endmodule
